leaf_spine_uplink: RTL and testbench
====================================

# leaf_spine_uplink

Leaf-side endpoint of the leaf-to-spine links inside a group: the opposite end of the spine router's leaf ports. It buffers flits from the local leaf and spreads them round-robin across the four spine routers. It also collects flits arriving from those spines, drops any that are not addressed to this leaf, and merges the rest into one ready/valid stream for the local leaf. The spine side is valid-only with no backpressure, so all flow control and loss accounting is done here.

## Interface
- GROUP_ID, 4'b0001, this block's group number; compared with flit bits [15:12].
- LEAF_ID, 0, this leaf's index within the group (0-3); compared with flit bits [11:10].
- DWIDTH, 16, flit width. Values below 16 are unsupported.
- FIFO_DEPTH, 8, depth of the TX FIFO and of each RX FIFO; must be a power of two, at least 2.
- NUM_SPINES, 4, number of spine links (fixed at 4).
- clk  in  1  single clock; everything is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- local_tx_data  in  DWIDTH  flit from the leaf.
- local_tx_valid  in  1  leaf offers a flit.
- local_tx_ready  out  1  block accepts; equals "TX FIFO not full".
- up_data  out  NUM_SPINES*DWIDTH  to spine k's leaf input; slice k is [k*DWIDTH +: DWIDTH].
- up_valid  out  NUM_SPINES  one-cycle pulse per flit sent to spine k.
- dn_data  in  NUM_SPINES*DWIDTH  from spine k's leaf output.
- dn_valid  in  NUM_SPINES  flit present from spine k.
- local_rx_data  out  DWIDTH  flit to the leaf.
- local_rx_valid  out  1  a flit is offered to the leaf.
- local_rx_ready  in  1  leaf accepts the flit.
- drop_count  out  8  RX-FIFO overflow drops; saturating.
- misroute_count  out  8  misaddressed-flit drops; saturating.

## Operation
- **Flit format:** single-flit packets. Destination is flit[15:10] = {group[3:0], leaf[1:0]}; remaining bits are payload and are not interpreted.
- **TX path:**
  - A flit is accepted when local_tx_valid and local_tx_ready are both high; it is written to the TX FIFO.
  - The send stage pops at most one flit per cycle and drives it on the spine slice selected by rr_tx. Only that slice's up_valid bit is high.
  - rr_tx advances 0→1→2→3→0 after each sent flit and holds when nothing is sent.
  - up_data slices not being driven hold their last value.
- **RX path:**
  - Each spine has its own RX FIFO. A flit with dn_valid[k] high is written to FIFO k only if its group equals GROUP_ID and its leaf equals LEAF_ID.
  - A misaddressed flit is not written and increments misroute_count.
  - A correctly addressed flit that arrives while FIFO k is full is not written and increments drop_count.
- **RX merge:** a round-robin arbiter (rr_rx) picks among non-empty RX FIFOs and loads the chosen flit into a registered output stage. The stage reloads when it is empty, or in the same cycle its flit is accepted (local_rx_valid and local_rx_ready both high). rr_rx moves to one past the winner.
- **Counters:** each cycle a counter adds the number of events across all spines (0-4) and saturates at 255. Both counters are cleared only by reset.

## Timing
- **Reset values:** local_tx_ready=0 while reset is asserted and 1 from the first edge after release; up_valid=0; up_data=0; local_rx_valid=0; local_rx_data=0; drop_count=0; misroute_count=0; rr_tx=0; rr_rx=0; all FIFOs empty.
- **TX latency:** a flit accepted at edge N is on up_* in the cycle after edge N+1. Sustained throughput is 1 flit/cycle.
- **RX latency:** a flit written at edge N, with the output stage free, makes local_rx_valid high after edge N+1.
- **Output stability:** local_rx_data and local_rx_valid do not change while local_rx_valid=1 and local_rx_ready=0.
- **TX FIFO full:** local_tx_ready is low during the full cycle. A pop in that cycle does not raise ready until the next cycle.
- **RX FIFO k full:** a simultaneous write and pop on FIFO k in the same cycle counts as space, so the write succeeds.
- **Simultaneous arrivals:** all four spines may deliver in the same cycle, and all four writes happen in parallel.
- **Mid-operation reset:** in-flight flits are lost, and outputs return to their reset values asynchronously.

## Structure
- Shared package noc_pkg holds the flit field positions (DEST_GRP_HI/LO, DEST_LEAF_HI/LO) and the counter width. The spine router uses the same definitions.
- One sub-module, uplink_fifo: a synchronous FIFO, instantiated 5 times (1 TX, 4 RX). Ports: push, pop, data in/out, full, empty, with show-ahead read.

## Test plan
- **TX spreading:** GROUP_ID=1, LEAF_ID=2. Send 8 back-to-back flits 0x1000-0x1007 → up_valid pulses one spine at a time in order 0,1,2,3,0,1,2,3, carrying 0x1000-0x1007 in order; first pulse in the cycle after the second edge following the first accept.
- **TX backpressure:** the send stage is not stalled by the spines, so fill the TX FIFO by offering flits every cycle starting at the edge reset releases. local_tx_ready must never accept a ninth flit that would overflow; all accepted flits emerge exactly once.
- **RX filter:** GROUP_ID=1, LEAF_ID=2. Spine 1 sends 0x1800 (group 1, leaf 2) and 0x1400 (leaf 1) → only 0x1800 is delivered to the leaf; misroute_count=1.
- **RX merge:** all four spines present 0x18A0-0x18A3 in one cycle with local_rx_ready=1 → delivered in order A0, A1, A2, A3 on four consecutive cycles.
- **Overflow:** hold local_rx_ready=0 and drive spine 0 with 12 valid, correctly addressed flits → 8 stored plus 1 in the output stage; drop_count=3; the first 9 are then delivered in order.
- **Reset mid-traffic:** assert reset while both FIFOs hold data → all outputs and counters are 0 immediately; after release, the first new TX flit goes to spine 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: destination field positions inside a flit and the width of the
// loss counters. The spine router uses the same definitions.
package noc_pkg;

    localparam int unsigned DEST_GRP_HI  = 15;
    localparam int unsigned DEST_GRP_LO  = 12;
    localparam int unsigned DEST_LEAF_HI = 11;
    localparam int unsigned DEST_LEAF_LO = 10;
    localparam int unsigned CNT_W        = 8;

    // Adds a per-cycle event count (0-4) and clamps at the counter's maximum value.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [2:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/uplink_fifo.sv
// Synchronous show-ahead FIFO. A push into a full FIFO succeeds only when a pop happens in
// the same cycle.
module uplink_fifo #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DWIDTH-1:0] din,
    input  logic              pop,
    output logic [DWIDTH-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr_q;
    logic [AW-1:0]     rptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= din;
    end

endmodule

// File: rtl/leaf_spine_uplink.sv
// Leaf end of the leaf-to-spine links: spreads local flits round-robin over the spines and
// merges correctly addressed spine flits back into one ready/valid stream with loss counting.
module leaf_spine_uplink
    import noc_pkg::*;
#(
    parameter logic [3:0]  GROUP_ID   = 4'b0001,
    parameter int unsigned LEAF_ID    = 0,
    parameter int unsigned DWIDTH     = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned NUM_SPINES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DWIDTH-1:0]            local_tx_data,
    input  logic                         local_tx_valid,
    output logic                         local_tx_ready,
    output logic [NUM_SPINES*DWIDTH-1:0] up_data,
    output logic [NUM_SPINES-1:0]        up_valid,
    input  logic [NUM_SPINES*DWIDTH-1:0] dn_data,
    input  logic [NUM_SPINES-1:0]        dn_valid,
    output logic [DWIDTH-1:0]            local_rx_data,
    output logic                         local_rx_valid,
    input  logic                         local_rx_ready,
    output logic [CNT_W-1:0]             drop_count,
    output logic [CNT_W-1:0]             misroute_count
);

    localparam int unsigned SW       = $clog2(NUM_SPINES);
    localparam logic [1:0]  LEAF_SEL = 2'(LEAF_ID);

    // ---------------- TX path ----------------
    logic              ready_en_q;
    logic              tx_full;
    logic              tx_empty;
    logic              tx_pop;
    logic [DWIDTH-1:0] tx_dout;
    logic [SW-1:0]     rr_tx_q;

    // Keeps ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ready_en_q <= 1'b0;
        else        ready_en_q <= 1'b1;
    end

    assign local_tx_ready = ready_en_q & ~tx_full;
    assign tx_pop         = ~tx_empty;

    uplink_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (local_tx_valid & local_tx_ready),
        .din   (local_tx_data),
        .pop   (tx_pop),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_valid <= '0;
            up_data  <= '0;
            rr_tx_q  <= '0;
        end else begin
            up_valid <= '0;
            if (tx_pop) begin
                up_valid[rr_tx_q]                   <= 1'b1;
                up_data[rr_tx_q*DWIDTH +: DWIDTH] <= tx_dout;
                rr_tx_q                             <= rr_tx_q + SW'(1);
            end
        end
    end

    // ---------------- RX path ----------------
    logic [DWIDTH-1:0]     rx_dout [NUM_SPINES];
    logic [NUM_SPINES-1:0] rx_full;
    logic [NUM_SPINES-1:0] rx_empty;
    logic [NUM_SPINES-1:0] rx_pop;
    logic [NUM_SPINES-1:0] addr_ok;
    logic [NUM_SPINES-1:0] rx_push;
    logic [NUM_SPINES-1:0] drop_ev;
    logic [NUM_SPINES-1:0] misroute_ev;

    for (genvar k = 0; k < NUM_SPINES; k++) begin : g_rx
        logic [DWIDTH-1:0] flit;
        assign flit = dn_data[k*DWIDTH +: DWIDTH];
        assign addr_ok[k] = (flit[DEST_GRP_HI:DEST_GRP_LO] == GROUP_ID) &&
                            (flit[DEST_LEAF_HI:DEST_LEAF_LO] == LEAF_SEL);
        assign rx_push[k]     = dn_valid[k] & addr_ok[k];
        assign misroute_ev[k] = dn_valid[k] & ~addr_ok[k];
        // A pop in the same cycle frees a slot, so a full FIFO still takes the write.
        assign drop_ev[k]     = rx_push[k] & rx_full[k] & ~rx_pop[k];

        uplink_fifo #(
            .DWIDTH (DWIDTH),
            .DEPTH  (FIFO_DEPTH)
        ) u_rx_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (rx_push[k]),
            .din   (flit),
            .pop   (rx_pop[k]),
            .dout  (rx_dout[k]),
            .full  (rx_full[k]),
            .empty (rx_empty[k])
        );
    end

    // ---------------- RX merge ----------------
    logic          rx_load;
    logic          grant_valid;
    logic [SW-1:0] grant;
    logic [SW-1:0] idx;
    logic [SW-1:0] rr_rx_q;

    assign rx_load = ~local_rx_valid | local_rx_ready;

    always_comb begin
        grant_valid = 1'b0;
        grant       = rr_rx_q;
        idx         = rr_rx_q;
        rx_pop      = '0;
        if (rx_load) begin
            for (int i = 0; i < NUM_SPINES; i++) begin
                idx = rr_rx_q + SW'(i);
                if (!grant_valid && !rx_empty[idx]) begin
                    grant_valid = 1'b1;
                    grant       = idx;
                end
            end
        end
        if (grant_valid) rx_pop[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            local_rx_valid <= 1'b0;
            local_rx_data  <= '0;
            rr_rx_q        <= '0;
        end else if (rx_load) begin
            local_rx_valid <= grant_valid;
            if (grant_valid) begin
                local_rx_data <= rx_dout[grant];
                rr_rx_q       <= grant + SW'(1);
            end
        end
    end

    // ---------------- Loss counters ----------------
    logic [2:0] drop_n;
    logic [2:0] mis_n;

    always_comb begin
        drop_n = '0;
        mis_n  = '0;
        for (int k = 0; k < NUM_SPINES; k++) begin
            drop_n = drop_n + 3'(drop_ev[k]);
            mis_n  = mis_n + 3'(misroute_ev[k]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count     <= '0;
            misroute_count <= '0;
        end else begin
            drop_count     <= sat_add(drop_count, drop_n);
            misroute_count <= sat_add(misroute_count, mis_n);
        end
    end

endmodule

// File: tb/tb_leaf_spine_uplink.sv
// Directed self-checking bench for leaf_spine_uplink (GROUP_ID=1, LEAF_ID=2).
module tb_leaf_spine_uplink;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] local_tx_data = '0;
    logic        local_tx_valid = 1'b0;
    logic        local_tx_ready;
    logic [63:0] up_data;
    logic [3:0]  up_valid;
    logic [63:0] dn_data = '0;
    logic [3:0]  dn_valid = '0;
    logic [15:0] local_rx_data;
    logic        local_rx_valid;
    logic        local_rx_ready = 1'b0;
    logic [7:0]  drop_count;
    logic [7:0]  misroute_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    leaf_spine_uplink #(
        .GROUP_ID   (4'b0001),
        .LEAF_ID    (2),
        .DWIDTH     (16),
        .FIFO_DEPTH (8),
        .NUM_SPINES (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .local_tx_data  (local_tx_data),
        .local_tx_valid (local_tx_valid),
        .local_tx_ready (local_tx_ready),
        .up_data        (up_data),
        .up_valid       (up_valid),
        .dn_data        (dn_data),
        .dn_valid       (dn_valid),
        .local_rx_data  (local_rx_data),
        .local_rx_valid (local_rx_valid),
        .local_rx_ready (local_rx_ready),
        .drop_count     (drop_count),
        .misroute_count (misroute_count)
    );

    task automatic apply_reset();
        reset          = 1'b0;
        local_tx_valid = 1'b0;
        dn_valid       = '0;
        local_rx_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({local_tx_ready, up_valid, local_rx_valid} !== 6'b0 || up_data !== 64'h0 ||
            local_rx_data !== 16'h0 || drop_count !== 8'h0 || misroute_count !== 8'h0) begin
            errors++;
            $display("FAIL reset_values: got ready=%b up_valid=%b up_data=%h rx_valid=%b rx_data=%h drop=%0d mis=%0d, expected all 0",
                     local_tx_ready, up_valid, up_data, local_rx_valid, local_rx_data,
                     drop_count, misroute_count);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (local_tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: got %b expected 1", local_tx_ready);
        end
    endtask

    task automatic test_tx_spread();
        logic [3:0]  exp_v;
        logic [15:0] exp_d;
        local_tx_valid = 1'b1;
        local_tx_data  = 16'h1000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c < 7) local_tx_data = 16'h1000 + 16'(c + 1);
            else       local_tx_valid = 1'b0;
            exp_v = (c >= 1 && c <= 8) ? 4'(1 << ((c - 1) % 4)) : 4'b0;
            checks++;
            if (up_valid !== exp_v) begin
                errors++;
                $display("FAIL tx_spread_valid[%0d]: got %b expected %b", c, up_valid, exp_v);
            end
            if (exp_v != 4'b0) begin
                exp_d = 16'h1000 + 16'(c - 1);
                checks++;
                if (up_data[((c - 1) % 4)*16 +: 16] !== exp_d) begin
                    errors++;
                    $display("FAIL tx_spread_data[%0d]: got %h expected %h",
                             c, up_data[((c - 1) % 4)*16 +: 16], exp_d);
                end
            end
        end
    endtask

    task automatic test_tx_backpressure();
        logic [15:0] exp_q[$];
        logic [15:0] prev_data;
        logic [15:0] exp_d;
        logic [3:0]  exp_v;
        logic        prev_acc;
        int          accepted = 0;
        int          received = 0;
        int          rr = 0;
        reset          = 1'b0;
        local_tx_valid = 1'b1;
        local_tx_data  = 16'h2000;
        @(negedge clk);
        reset     = 1'b1;
        prev_acc  = local_tx_valid & local_tx_ready;
        prev_data = local_tx_data;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (prev_acc) begin
                exp_q.push_back(prev_data);
                accepted++;
                local_tx_data = prev_data + 16'h1;
            end
            if (accepted == 12) local_tx_valid = 1'b0;
            if (up_valid !== 4'b0) begin
                exp_v = 4'(1 << rr);
                exp_d = (exp_q.size() != 0) ? exp_q[0] : 16'hxxxx;
                checks++;
                if (up_valid !== exp_v || up_data[rr*16 +: 16] !== exp_d) begin
                    errors++;
                    $display("FAIL tx_bp_flit[%0d]: got valid=%b data=%h expected valid=%b data=%h",
                             received, up_valid, up_data[rr*16 +: 16], exp_v, exp_d);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                rr = (rr + 1) % 4;
                received++;
            end
            checks++;
            if (accepted - received > 9) begin
                errors++;
                $display("FAIL tx_bp_occupancy: got %0d outstanding expected at most 9",
                         accepted - received);
            end
            prev_acc  = local_tx_valid & local_tx_ready;
            prev_data = local_tx_data;
        end
        checks++;
        if (received !== 12 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL tx_bp_total: got %0d sent, %0d pending expected 12 sent, 0 pending",
                     received, exp_q.size());
        end
    endtask

    task automatic test_rx_filter();
        apply_reset();
        local_rx_ready = 1'b1;
        dn_valid       = 4'b0010;
        dn_data        = '0;
        dn_data[31:16] = 16'h1800;
        @(negedge clk);
        dn_data[31:16] = 16'h1400;
        checks++;
        if (local_rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rx_filter_latency: got valid=%b expected 0", local_rx_valid);
        end
        @(negedge clk);
        dn_valid = '0;
        checks++;
        if (local_rx_valid !== 1'b1 || local_rx_data !== 16'h1800 || misroute_count !== 8'd1) begin
            errors++;
            $display("FAIL rx_filter_deliver: got valid=%b data=%h mis=%0d expected 1 1800 1",
                     local_rx_valid, local_rx_data, misroute_count);
        end
        @(negedge clk);
        checks++;
        if (local_rx_valid !== 1'b0 || misroute_count !== 8'd1 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL rx_filter_reject: got valid=%b mis=%0d drop=%0d expected 0 1 0",
                     local_rx_valid, misroute_count, drop_count);
        end
    endtask

    task automatic test_rx_merge();
        apply_reset();
        local_rx_ready = 1'b1;
        dn_valid       = 4'b1111;
        dn_data        = {16'h18A3, 16'h18A2, 16'h18A1, 16'h18A0};
        @(negedge clk);
        dn_valid = '0;
        checks++;
        if (local_rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rx_merge_latency: got valid=%b expected 0", local_rx_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (local_rx_valid !== 1'b1 || local_rx_data !== 16'h18A0 + 16'(i)) begin
                errors++;
                $display("FAIL rx_merge[%0d]: got valid=%b data=%h expected 1 %h",
                         i, local_rx_valid, local_rx_data, 16'h18A0 + 16'(i));
            end
        end
        @(negedge clk);
        checks++;
        if (local_rx_valid !== 1'b0 || misroute_count !== 8'd0) begin
            errors++;
            $display("FAIL rx_merge_end: got valid=%b mis=%0d expected 0 0",
                     local_rx_valid, misroute_count);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        local_rx_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            dn_valid       = 4'b0001;
            dn_data[15:0]  = 16'h1800 + 16'(i);
        end
        @(negedge clk);
        dn_valid = '0;
        checks++;
        if (drop_count !== 8'd3 || local_rx_valid !== 1'b1 || local_rx_data !== 16'h1800) begin
            errors++;
            $display("FAIL overflow_state: got drop=%0d valid=%b data=%h expected 3 1 1800",
                     drop_count, local_rx_valid, local_rx_data);
        end
        @(negedge clk);
        checks++;
        if (local_rx_valid !== 1'b1 || local_rx_data !== 16'h1800 || drop_count !== 8'd3) begin
            errors++;
            $display("FAIL overflow_hold: got valid=%b data=%h drop=%0d expected 1 1800 3",
                     local_rx_valid, local_rx_data, drop_count);
        end
        local_rx_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            @(negedge clk);
            checks++;
            if (local_rx_valid !== 1'b1 || local_rx_data !== 16'h1800 + 16'(i)) begin
                errors++;
                $display("FAIL overflow_drain[%0d]: got valid=%b data=%h expected 1 %h",
                         i, local_rx_valid, local_rx_data, 16'h1800 + 16'(i));
            end
        end
        @(negedge clk);
        checks++;
        if (local_rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL overflow_empty: got valid=%b expected 0", local_rx_valid);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        local_rx_ready = 1'b0;
        local_tx_valid = 1'b1;
        local_tx_data  = 16'h3100;
        dn_valid       = 4'b0101;
        dn_data        = '0;
        dn_data[15:0]  = 16'h1855;
        dn_data[47:32] = 16'h0000;
        @(negedge clk);
        local_tx_data = 16'h3101;
        dn_valid      = 4'b0001;
        dn_data[15:0] = 16'h1856;
        @(negedge clk);
        local_tx_valid = 1'b0;
        dn_valid       = '0;
        checks++;
        if (up_valid !== 4'b0001 || local_rx_valid !== 1'b1 || misroute_count !== 8'd1) begin
            errors++;
            $display("FAIL mid_reset_pre: got up_valid=%b rx_valid=%b mis=%0d expected 0001 1 1",
                     up_valid, local_rx_valid, misroute_count);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({local_tx_ready, up_valid, local_rx_valid} !== 6'b0 || up_data !== 64'h0 ||
            local_rx_data !== 16'h0 || drop_count !== 8'h0 || misroute_count !== 8'h0) begin
            errors++;
            $display("FAIL mid_reset_async: got ready=%b up_valid=%b up_data=%h rx_valid=%b rx_data=%h drop=%0d mis=%0d, expected all 0",
                     local_tx_ready, up_valid, up_data, local_rx_valid, local_rx_data,
                     drop_count, misroute_count);
        end
        @(negedge clk);
        reset = 1'b1;
        local_rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (up_valid !== 4'b0 || local_rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_flushed: got up_valid=%b rx_valid=%b expected 0 0",
                     up_valid, local_rx_valid);
        end
        local_tx_valid = 1'b1;
        local_tx_data  = 16'h3200;
        @(negedge clk);
        local_tx_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (up_valid !== 4'b0001 || up_data[15:0] !== 16'h3200) begin
            errors++;
            $display("FAIL mid_reset_first_tx: got valid=%b data=%h expected 0001 3200",
                     up_valid, up_data[15:0]);
        end
    endtask

    initial begin
        test_reset();
        test_tx_spread();
        test_tx_backpressure();
        test_rx_filter();
        test_rx_merge();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
